// File: rtl/bridge_arbiter.sv
// Round-robin arbiter sharing one downstream bridge target between num_req requesters.
// One transaction in flight; reads wait rd_latency cycles and return data with a valid pulse.
module bridge_arbiter #(
  parameter int num_req    = 4,
  parameter int data_width = 32,
  parameter int addr_width = 32,
  parameter int rd_latency = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [num_req-1:0]               req_wr,
  input  logic [num_req-1:0]               req_rd,
  input  logic [num_req*addr_width-1:0]    req_addr,
  input  logic [num_req*data_width-1:0]    req_wr_data,
  output logic [num_req-1:0]               req_ack,
  output logic [num_req-1:0]               rsp_valid,
  output logic [data_width-1:0]            rsp_data,
  output logic [addr_width-1:0]            out_addr,
  output logic [data_width-1:0]            out_wr_data,
  output logic                             out_wr,
  output logic                             out_rd,
  input  logic [data_width-1:0]            out_rd_data,
  output logic                             busy
);

  // state | meaning
  // IDLE  | arbitrate among pending requesters each cycle
  // ISSUE | strobe and ack high for the granted requester (one cycle)
  // WAIT  | read in flight, counting down the target latency
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int iw = (num_req > 1) ? $clog2(num_req) : 1;
  localparam logic [num_req-1:0] one_hot0 = {{(num_req-1){1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [iw-1:0]   last, win;
  logic            any_pend, cur_wr;
  logic [3:0]      cnt;
  logic [num_req-1:0] pend;

  assign pend = req_wr | req_rd;

  // Search starts just after the last grant, so the previous winner has lowest priority.
  always_comb begin
    int j;
    win      = last;
    any_pend = 1'b0;
    for (int k = 1; k <= num_req; k++) begin
      j = int'(last) + k;
      if (j >= num_req) j = j - num_req;
      if (!any_pend && pend[iw'(j)]) begin
        any_pend = 1'b1;
        win      = iw'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_pend) state_nxt = ISSUE;
      ISSUE:   state_nxt = cur_wr ? IDLE : WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ack = '0;
    out_wr  = 1'b0;
    out_rd  = 1'b0;
    if (state == ISSUE) begin
      req_ack = one_hot0 << last;
      out_wr  = cur_wr;
      out_rd  = !cur_wr;
    end
    busy = (state != IDLE);
  end

  // Datapath: last doubles as the owner of the transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last        <= iw'(num_req - 1);
      cur_wr      <= 1'b0;
      cnt         <= 4'd0;
      out_addr    <= '0;
      out_wr_data <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: if (any_pend) begin
          last        <= win;
          cur_wr      <= req_wr[win];
          out_addr    <= req_addr[int'(win)*addr_width +: addr_width];
          out_wr_data <= req_wr_data[int'(win)*data_width +: data_width];
        end
        ISSUE: if (!cur_wr) cnt <= 4'(rd_latency - 1);
        WAIT: begin
          if (cnt == 4'd0) begin
            rsp_data  <= out_rd_data;
            rsp_valid <= one_hot0 << last;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Randomized bench for bridge_arbiter against a transaction-scheduling reference model.
module tb_bridge_arbiter;
  localparam int N = 4, DW = 32, AW = 32, L = 2, MAXC = 2100;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [N-1:0] req_wr, req_rd, req_ack, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wr_data;
  logic [DW-1:0] rsp_data, out_wr_data, out_rd_data;
  logic [AW-1:0] out_addr;
  logic out_wr, out_rd, busy;

  bridge_arbiter #(.num_req(N), .data_width(DW), .addr_width(AW), .rd_latency(L)) dut (
    .clk(clk), .reset_n(reset_n), .req_wr(req_wr), .req_rd(req_rd), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .out_addr(out_addr), .out_wr_data(out_wr_data), .out_wr(out_wr), .out_rd(out_rd),
    .out_rd_data(out_rd_data), .busy(busy));

  always #5 clk = ~clk;

  // requester agents
  logic [N-1:0] wr = '0, rd = '0, ack_seen = '0;
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];
  bit hold_all = 0, quiet = 0, inject = 0;

  always_comb begin
    req_wr = wr;
    req_rd = rd;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]    = a[i];
      req_wr_data[i*DW +: DW] = d[i];
    end
  end

  // reference model: per-cycle expectations scheduled when a grant is decided
  int cyc, next_dec, m_last, checks = 0, errors = 0;
  int e_ack [MAXC], e_rsp [MAXC];
  bit e_wr [MAXC], e_rd [MAXC], e_busy [MAXC];
  logic [AW-1:0] iss_addr [MAXC];
  logic [DW-1:0] iss_data [MAXC], drv [MAXC];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  int nacks, ack_cyc [6], ack_idx [6];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < MAXC; c++) begin
      e_ack[c] = -1; e_rsp[c] = -1; e_wr[c] = 0; e_rd[c] = 0; e_busy[c] = 0;
    end
    m_last = N - 1; next_dec = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  task automatic model_cycle();
    logic [N-1:0] pend, ea, ev;
    int w;
    if (e_ack[cyc] >= 0) begin m_addr = iss_addr[cyc]; m_wdata = iss_data[cyc]; end
    if (e_rsp[cyc] >= 0) m_rdata = drv[cyc-1];
    ea = (e_ack[cyc] >= 0) ? (N'(1) << e_ack[cyc]) : '0;
    ev = (e_rsp[cyc] >= 0) ? (N'(1) << e_rsp[cyc]) : '0;
    chk("req_ack", req_ack, ea);
    chk("rsp_valid", rsp_valid, ev);
    chk("out_wr", out_wr, e_wr[cyc]);
    chk("out_rd", out_rd, e_rd[cyc]);
    chk("busy", busy, e_busy[cyc]);
    chk("out_addr", out_addr, m_addr);
    chk("out_wr_data", out_wr_data, m_wdata);
    chk("rsp_data", rsp_data, m_rdata);
    if (req_ack != 0 && nacks < 6) begin
      ack_cyc[nacks] = cyc;
      for (int i = 0; i < N; i++) if (req_ack[i]) ack_idx[nacks] = i;
      nacks++;
    end
    ack_seen = req_ack;
    pend = wr | rd;
    if (cyc >= next_dec && pend != 0 && cyc + 3 + L < MAXC) begin
      w = -1;
      for (int k = 1; k <= N; k++) if (w < 0 && pend[(m_last + k) % N]) w = (m_last + k) % N;
      m_last = w;
      e_ack[cyc+1] = w;
      iss_addr[cyc+1] = a[w];
      iss_data[cyc+1] = d[w];
      e_busy[cyc+1] = 1;
      if (wr[w]) begin
        e_wr[cyc+1] = 1;
        next_dec = cyc + 2;
      end else begin
        e_rd[cyc+1] = 1;
        for (int c = cyc + 1; c <= cyc + 1 + L; c++) e_busy[c] = 1;
        e_rsp[cyc+2+L] = w;
        next_dec = cyc + 2 + L;
      end
    end
  endtask

  task automatic agents();
    for (int i = 0; i < N; i++) begin
      if (ack_seen[i] && !hold_all) begin wr[i] = 0; rd[i] = 0; end
      if (!quiet && !hold_all && !(wr[i] | rd[i]) && $urandom_range(0, 3) == 0) begin
        a[i] = $urandom; d[i] = $urandom;
        case ($urandom_range(0, 2))
          0: wr[i] = 1;
          1: rd[i] = 1;
          default: begin wr[i] = 1; rd[i] = 1; end
        endcase
      end
    end
    if (inject) begin rd[1] = 1; wr[1] = 0; a[1] = 32'h40; d[1] = $urandom; inject = 0; end
  endtask

  task automatic drive_rd_data();
    logic [DW-1:0] v;
    v = $urandom;
    drv[cyc] = v;
    out_rd_data = v;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    agents();
    drive_rd_data();
    @(negedge clk);
    model_cycle();
  endtask

  // called #1 after a posedge; the remainder of this clock period is cycle 0
  task automatic release_reset();
    cyc = 0;
    model_clear();
    ack_seen = '0;
    reset_n = 1'b1;
    drive_rd_data();
    @(negedge clk);
    model_cycle();
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin a[i] = $urandom; d[i] = $urandom; end
    out_rd_data = '0;
    nacks = 0;
    // phase 1: every requester writing continuously from reset
    hold_all = 1;
    wr = '1;
    repeat (3) @(posedge clk);
    #1 release_reset();
    repeat (20) step();
    for (int i = 0; i < 6; i++) begin
      chk("rr_idx", ack_idx[i], i % N);
      chk("rr_cyc", ack_cyc[i], 2 * i + 1);
    end
    // phase 2: random traffic
    hold_all = 0;
    repeat (1500) step();
    // phase 3: drain, issue a read, reset in its WAIT
    quiet = 1;
    n = 0;
    while (((wr | rd) != 0 || busy) && n < 40) begin step(); n++; end
    if (n >= 40) chk("drain_timeout", 0, 1);
    inject = 1;
    n = 0;
    do begin step(); n++; end while (!out_rd && n < 10);
    if (!out_rd) chk("read_issue_timeout", 0, 1);
    step();
    chk("in_wait_busy", busy, 1);
    wr = 4'b0101; rd = '0;
    reset_n = 1'b0;
    #1;
    chk("rst_req_ack", req_ack, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_wr_data", out_wr_data, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_busy", busy, 0);
    nacks = 0;
    repeat (2) @(posedge clk);
    #1 release_reset();
    repeat (12) step();
    chk("post_rst_first", ack_idx[0], 0);
    chk("post_rst_second", ack_idx[1], 2);
    chk("post_rst_nacks", nacks, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bridge_arbiter.md
Name: bridge_arbiter

Overview:
- Shares one downstream bridge target between num_req independent requesters, all on one clock domain.
- Typical use: several cores' register blocks or a CPU plus a debug port reaching one bridge_cdc input or register file.
- Round-robin, one transaction in flight at a time.
- Reads wait a fixed target latency, capture rd_data, and return it to the owning requester with a valid pulse.

Parameters:
- num_req, 4, number of requesters (2..8)
- data_width, 32, bridge data width
- addr_width, 32, bridge address width
- rd_latency, 2, cycles from the out_rd strobe cycle to the cycle out_rd_data is valid (1..15)

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- req_wr  in  num_req  per-requester write request, level, held until acked
- req_rd  in  num_req  per-requester read request, level, held until acked
- req_addr  in  num_req*addr_width  packed addresses; requester i at slice i
- req_wr_data  in  num_req*data_width  packed write data
- req_ack  out  num_req  one-cycle pulse: request i issued downstream
- rsp_valid  out  num_req  one-cycle pulse: read data for i on rsp_data
- rsp_data  out  data_width  read data shared by all requesters, qualified by rsp_valid
- out_addr  out  addr_width  downstream address
- out_wr_data  out  data_width  downstream write data
- out_wr  out  1  downstream write strobe, one cycle
- out_rd  out  1  downstream read strobe, one cycle
- out_rd_data  in  data_width  downstream read data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs 0: req_ack, rsp_valid, rsp_data, out_*, busy.
  - Round-robin pointer last = num_req-1, so requester 0 has first priority.
- Requester i pending = req_wr[i] | req_rd[i]. If both are set, the request is a write; req_rd is ignored for that transaction.
- Requester protocol: hold the request and its addr/data stable until req_ack[i]=1 is sampled, then deassert on that same edge.
- State IDLE:
  - Each cycle with any request pending, select winner w = first pending index searching last+1, last+2, ... modulo num_req.
  - On that edge: register out_addr/out_wr_data from slice w; set out_wr or out_rd, req_ack[w]=1, last=w; go to ISSUE.
  - With no requests pending, stay in IDLE; out_* keep their last values and strobes stay 0.
- State ISSUE (exactly one cycle; strobes and ack high in this cycle only):
  - Write: go to IDLE.
  - Read: load wait counter = rd_latency-1; go to WAIT.
- State WAIT: decrement each cycle. In the cycle the counter is 0, sample out_rd_data into rsp_data, set rsp_valid[w]=1, go to IDLE.
  - rsp_data holds its value until the next read completes.
- Timing:
  - Request first seen at cycle T gives the strobe and ack at T+1.
  - Write: next arbitration decision at T+2, so back-to-back writes run at one per 2 cycles.
  - Read: out_rd_data is sampled in cycle T+1+rd_latency; rsp_valid is high at T+2+rd_latency.
  - Next arbitration decision in that same cycle, T+2+rd_latency.
- No new request is issued while state != IDLE. Requests arriving then wait and are not lost, since they are level-held.
- Fairness: with all requesters continuously pending, grants rotate 0,1,...,num_req-1,0. No requester waits more than num_req transactions.
- rsp_valid and req_ack are never high for more than one cycle per transaction. At most one bit of each vector is set.
- Reset mid-read: the transaction is abandoned, with no rsp_valid. The pointer returns to num_req-1. The requester must re-request.

Test Plan:
- Write, single requester: req_wr[2]=1, addr 0x0000_0010, data 0xDEAD_BEEF at T. Required: out_wr=1 with that addr/data and req_ack[2]=1 at T+1 only; busy high only at T+1.
- Read, rd_latency=2: req_rd[1]=1, addr 0x40, target drives 0x1234_5678 at T+3. Required: out_rd at T+1; rsp_valid[1]=1 and rsp_data=0x1234_5678 at T+4; other rsp_valid bits stay 0.
- Round-robin: all four req_wr held continuously from reset. Required: ack order 0,1,2,3,0,1 at cycles 1,3,5,7,9,11.
- Contention during a read: req_rd[0] issued; req_wr[3] asserted during WAIT. Required: no out_wr until the read's rsp_valid cycle; req_ack[3] one cycle after that.
- Write precedence: req_wr[1]=req_rd[1]=1. Required: out_wr=1, out_rd=0, and no rsp_valid[1].
- Reset mid-read: reset_n low in WAIT. Required: all outputs 0 immediately. After release, a pending req_wr[2] with req_wr[0] also pending is granted to 0 first.
